axi4_reg_slave: RTL and testbench

- AXI4 (full) slave register bank; the functional core of the `chip` top level.
- `chip` exposes only aclk/aresetn and internally wires an AXI4 master, at hierarchy ex_design.axi_vip_mst, to this block's slave port.
- Provides NUM_REGS 32-bit registers, with single-beat and INCR/FIXED burst access.

---
 rtl/axi4_reg_pkg.sv | 28 ++
 rtl/axi4_reg_file.sv | 47 ++++
 rtl/axi4_reg_slave.sv | 257 +++++++++++++++++++++++++
 tb/tb_axi4_reg_slave.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_reg_pkg.sv
// Shared constants and FSM state types for the AXI4 register slave.
package axi4_reg_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Response codes are ordered by severity, so the worse one is the larger.
  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi4_reg_file.sv
// Register array: byte-strobed write port, combinational read port.
// The last register is read-only and holds VERSION.
module axi4_reg_file #(
  parameter int          NUM_REGS = 16,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] VERSION  = 32'h0001_0000,
  parameter int          IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  we,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_strb,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_W-1:0]     rd_data
);

  localparam logic [IDX_W-1:0] RO_IDX = IDX_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Merge strobed bytes into the addressed register; the version slot never changes.
  always_comb begin
    regs_d = regs_q;
    if (we && (wr_idx != RO_IDX)) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wr_strb[b]) regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  // Register storage with asynchronous reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == NUM_REGS - 1) ? DATA_W'(VERSION) : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd_data = regs_q[rd_idx];

endmodule

// File: rtl/axi4_reg_slave.sv
// AXI4 slave exposing NUM_REGS 32-bit registers with single and burst access.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, one register updated per accepted beat
// W_RESP | bvalid high until the master takes the response
// R_IDLE | arready high, waiting for a read address
// R_DATA | rvalid high, current beat held until rready
module axi4_reg_slave
  import axi4_reg_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          ID_W     = 1,
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] VERSION  = 32'h0001_0000
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_W-1:0]     s_awid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic [2:0]          s_awsize,
  input  logic [1:0]          s_awburst,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [ID_W-1:0]     s_bid,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ID_W-1:0]     s_arid,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [7:0]          s_arlen,
  input  logic [2:0]          s_arsize,
  input  logic [1:0]          s_arburst,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [ID_W-1:0]     s_rid,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic                s_rvalid,
  input  logic                s_rready
);

  localparam int                IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(NUM_REGS * 4);

  // Transfer size is always treated as 4 bytes, so the size fields carry no information.
  logic unused_size;
  assign unused_size = ^{s_awsize, s_arsize};

  function automatic logic dec_err(input logic [ADDR_W-1:0] a);
    return a >= SPAN;
  endfunction

  // WRAP advances like INCR; only FIXED holds the address.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0] burst);
    return (burst == FIXED) ? a : a + ADDR_W'(4);
  endfunction

  wr_state_e         w_state_q, w_state_d;
  logic              awready_q, awready_d;
  logic [ADDR_W-1:0] waddr_q,   waddr_d;
  logic [7:0]        wlen_q,    wlen_d;
  logic [1:0]        wburst_q,  wburst_d;
  logic [7:0]        wbeat_q,   wbeat_d;
  logic [ID_W-1:0]   bid_q,     bid_d;
  logic [1:0]        bresp_q,   bresp_d;
  logic              rf_we;

  rd_state_e         r_state_q, r_state_d;
  logic              arready_q, arready_d;
  logic [ADDR_W-1:0] raddr_q,   raddr_d;
  logic [7:0]        rlen_q,    rlen_d;
  logic [1:0]        rburst_q,  rburst_d;
  logic [7:0]        rbeat_q,   rbeat_d;
  logic [ID_W-1:0]   rid_q,     rid_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic [1:0]        rresp_q,   rresp_d;
  logic              rlast_q,   rlast_d;

  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rf_rd_data;

  axi4_reg_file #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .VERSION  (VERSION),
    .IDX_W    (IDX_W)
  ) u_reg_file (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .we       (rf_we),
    .wr_idx   (waddr_q[IDX_W+1:2]),
    .wr_data  (s_wdata),
    .wr_strb  (s_wstrb),
    .rd_idx   (rd_addr[IDX_W+1:2]),
    .rd_data  (rf_rd_data)
  );

  // Write FSM: address capture, per-beat register update, response hold.
  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wburst_d  = wburst_q;
    wbeat_d   = wbeat_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    rf_we     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_awvalid && awready_q) begin
          waddr_d   = s_awaddr;
          wlen_d    = s_awlen;
          wburst_d  = s_awburst;
          bid_d     = s_awid;
          wbeat_d   = '0;
          bresp_d   = OKAY;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_wvalid) begin
          rf_we   = !dec_err(waddr_q);
          bresp_d = worst_resp(bresp_q, dec_err(waddr_q) ? DECERR : OKAY);
          waddr_d = next_addr(waddr_q, wburst_q);
          wbeat_d = wbeat_q + 8'd1;
          if (s_wlast || (wbeat_q == wlen_q)) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
  end

  // Write channel registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wburst_q  <= '0;
      wbeat_q   <= '0;
      bid_q     <= '0;
      bresp_q   <= OKAY;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wburst_q  <= wburst_d;
      wbeat_q   <= wbeat_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Read lookup address: the incoming address when idle, else the next beat's address.
  always_comb begin
    rd_addr = (r_state_q == R_IDLE) ? s_araddr : next_addr(raddr_q, rburst_q);
  end

  // Read FSM: beat data is loaded into output flops so it stays stable under backpressure.
  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rburst_d  = rburst_q;
    rbeat_d   = rbeat_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_arvalid && arready_q) begin
          raddr_d   = s_araddr;
          rlen_d    = s_arlen;
          rburst_d  = s_arburst;
          rid_d     = s_arid;
          rbeat_d   = '0;
          rdata_d   = dec_err(rd_addr) ? '0 : rf_rd_data;
          rresp_d   = dec_err(rd_addr) ? DECERR : OKAY;
          rlast_d   = (s_arlen == 8'd0);
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_rready) begin
          if (rlast_q) begin
            r_state_d = R_IDLE;
          end else begin
            raddr_d = rd_addr;
            rbeat_d = rbeat_q + 8'd1;
            rdata_d = dec_err(rd_addr) ? '0 : rf_rd_data;
            rresp_d = dec_err(rd_addr) ? DECERR : OKAY;
            rlast_d = ((rbeat_q + 8'd1) == rlen_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  // Read channel registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rburst_q  <= '0;
      rbeat_q   <= '0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rburst_q  <= rburst_d;
      rbeat_q   <= rbeat_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  assign s_awready = awready_q;
  assign s_wready  = (w_state_q == W_DATA);
  assign s_bvalid  = (w_state_q == W_RESP);
  assign s_bid     = bid_q;
  assign s_bresp   = bresp_q;
  assign s_arready = arready_q;
  assign s_rvalid  = (r_state_q == R_DATA);
  assign s_rid     = rid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;
  assign s_rlast   = rlast_q;

endmodule

// File: tb/tb_axi4_reg_slave.sv
// Directed bench for axi4_reg_slave with a transaction-level register model.
module tb_axi4_reg_slave;

  localparam int          NUM_REGS = 16;
  localparam logic [31:0] VERSION  = 32'h0001_0000;
  localparam logic [1:0]  B_FIXED  = 2'b00;
  localparam logic [1:0]  B_INCR   = 2'b01;
  localparam logic [1:0]  B_WRAP   = 2'b10;
  localparam logic [1:0]  R_OKAY   = 2'b00;
  localparam logic [1:0]  R_DEC    = 2'b11;

  logic        aclk, aresetn;
  logic [0:0]  s_awid, s_bid, s_arid, s_rid;
  logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata;
  logic [7:0]  s_awlen, s_arlen;
  logic [2:0]  s_awsize, s_arsize;
  logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
  logic        s_bvalid, s_bready, s_arvalid, s_arready;
  logic        s_rlast, s_rvalid, s_rready;

  axi4_reg_slave #(
    .ADDR_W(32), .DATA_W(32), .ID_W(1), .NUM_REGS(NUM_REGS), .VERSION(VERSION)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected, expected handshake", name);
  endtask

  // Register model
  logic [31:0] model [NUM_REGS];

  function automatic void model_reset();
    for (int i = 0; i < NUM_REGS; i++) model[i] = (i == NUM_REGS - 1) ? VERSION : 32'h0;
  endfunction

  function automatic logic in_range(input logic [31:0] a);
    return a < 32'(NUM_REGS * 4);
  endfunction

  function automatic logic [31:0] adv(input logic [31:0] a, input logic [1:0] burst);
    return (burst == B_FIXED) ? a : a + 32'd4;
  endfunction

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        id;
  } rexp_t;

  typedef struct {
    logic [1:0] resp;
    logic       id;
  } bexp_t;

  rexp_t       exp_r[$];
  bexp_t       exp_b[$];
  logic [31:0] got_r[$];
  logic [1:0]  got_b[$];

  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  // Compare process: every valid cycle is checked against the front expectation.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (s_rvalid) begin
        if (exp_r.size() == 0) fail_now("unexpected_rvalid");
        else begin
          chk("rdata", s_rdata, exp_r[0].data);
          chk("rresp", 32'(s_rresp), 32'(exp_r[0].resp));
          chk("rlast", 32'(s_rlast), 32'(exp_r[0].last));
          chk("rid",   32'(s_rid),   32'(exp_r[0].id));
          if (s_rready) begin
            got_r.push_back(s_rdata);
            void'(exp_r.pop_front());
          end
        end
      end
      if (s_bvalid) begin
        if (exp_b.size() == 0) fail_now("unexpected_bvalid");
        else begin
          chk("bresp", 32'(s_bresp), 32'(exp_b[0].resp));
          chk("bid",   32'(s_bid),   32'(exp_b[0].id));
          if (s_bready) begin
            got_b.push_back(s_bresp);
            void'(exp_b.pop_front());
          end
        end
      end
    end
  end

  task automatic aw_hs(input logic [31:0] addr, input logic [7:0] len,
                       input logic [1:0] burst, input logic id);
    int n = 0;
    s_awaddr = addr; s_awlen = len; s_awburst = burst; s_awid = id;
    s_awsize = 3'b010; s_awvalid = 1'b1;
    @(negedge aclk);
    while (!s_awready && n < 100) begin @(negedge aclk); n++; end
    if (!s_awready) fail_now("aw_timeout");
    @(posedge aclk); #1;
    s_awvalid = 1'b0;
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic id, input int nbeats);
    logic [31:0] a;
    logic [1:0]  resp;
    int n;
    aw_hs(addr, len, burst, id);
    a = addr; resp = R_OKAY;
    for (int i = 0; i < nbeats; i++) begin
      s_wdata = wd[i]; s_wstrb = ws[i]; s_wlast = (i == nbeats - 1); s_wvalid = 1'b1;
      n = 0;
      @(negedge aclk);
      while (!s_wready && n < 100) begin @(negedge aclk); n++; end
      if (!s_wready) fail_now("w_timeout");
      @(posedge aclk); #1;
      if (in_range(a)) begin
        if ((a >> 2) != NUM_REGS - 1)
          for (int b = 0; b < 4; b++) if (ws[i][b]) model[a >> 2][8*b +: 8] = wd[i][8*b +: 8];
      end else resp = R_DEC;
      a = adv(a, burst);
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    exp_b.push_back('{resp: resp, id: id});
    s_bready = 1'b1;
    n = 0;
    while (exp_b.size() != 0 && n < 100) begin @(posedge aclk); n++; end
    if (exp_b.size() != 0) begin fail_now("b_timeout"); exp_b.delete(); end
    #1 s_bready = 1'b0;
  endtask

  task automatic ar_issue(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic id, input logic rdy);
    logic [31:0] a;
    int n = 0;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      exp_r.push_back('{data: in_range(a) ? model[a >> 2] : 32'h0,
                        resp: in_range(a) ? R_OKAY : R_DEC,
                        last: (i == int'(len)), id: id});
      a = adv(a, burst);
    end
    s_araddr = addr; s_arlen = len; s_arburst = burst; s_arid = id;
    s_arsize = 3'b010; s_rready = rdy; s_arvalid = 1'b1;
    @(negedge aclk);
    while (!s_arready && n < 100) begin @(negedge aclk); n++; end
    if (!s_arready) fail_now("ar_timeout");
    @(posedge aclk); #1;
    s_arvalid = 1'b0;
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic id, input int stall);
    int n = 0;
    ar_issue(addr, len, burst, id, stall == 0);
    if (stall > 0) begin
      repeat (stall) @(posedge aclk);
      #1 s_rready = 1'b1;
    end
    while (exp_r.size() != 0 && n < 200) begin @(posedge aclk); n++; end
    if (exp_r.size() != 0) begin fail_now("r_timeout"); exp_r.delete(); end
    #1 s_rready = 1'b0;
  endtask

  function automatic logic [31:0] got_back(input int k);
    return got_r[got_r.size() - 1 - k];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = 3'b010; s_awburst = B_INCR;
    s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = 3'b010;
    s_arburst = B_INCR; s_arvalid = 1'b0; s_rready = 1'b0;
    model_reset();

    #22;
    chk("rst_awready", 32'(s_awready), 0);
    chk("rst_arready", 32'(s_arready), 0);
    chk("rst_wready",  32'(s_wready),  0);
    chk("rst_bvalid",  32'(s_bvalid),  0);
    chk("rst_rvalid",  32'(s_rvalid),  0);
    chk("rst_rdata",   s_rdata,        0);
    chk("rst_bresp",   32'(s_bresp),   0);
    chk("rst_rlast",   32'(s_rlast),   0);

    @(negedge aclk) aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_awready", 32'(s_awready), 1);
    chk("post_rst_arready", 32'(s_arready), 1);

    repeat (1000) @(posedge aclk);
    #1;

    read_burst(32'h0, 8'd0, B_INCR, 1'b1, 0);
    chk("lit_read0", got_back(0), 32'h0);
    read_burst(32'h0, 8'd0, B_INCR, 1'b1, 0);
    chk("lit_read0_again", got_back(0), 32'h0);

    wd[0] = 32'h1234_5678; ws[0] = 4'hF;
    write_burst(32'h0, 8'd0, B_INCR, 1'b0, 1);
    chk("lit_bresp_okay", 32'(got_b[got_b.size()-1]), 0);
    read_burst(32'h0, 8'd0, B_INCR, 1'b0, 0);
    chk("lit_read_12345678", got_back(0), 32'h1234_5678);

    wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
    write_burst(32'h4, 8'd0, B_INCR, 1'b1, 1);
    read_burst(32'h4, 8'd0, B_INCR, 1'b1, 0);
    chk("lit_strobe", got_back(0), 32'h00BB_00DD);

    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    write_burst(32'h10, 8'd3, B_INCR, 1'b1, 4);
    read_burst(32'h10, 8'd3, B_INCR, 1'b1, 3);
    for (int k = 0; k < 4; k++) chk("lit_burst_beat", got_back(3 - k), 32'(k + 1));

    read_burst(32'h3C, 8'd0, B_INCR, 1'b0, 0);
    chk("lit_version", got_back(0), VERSION);
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    write_burst(32'h3C, 8'd0, B_INCR, 1'b0, 1);
    chk("lit_ro_bresp", 32'(got_b[got_b.size()-1]), 0);
    read_burst(32'h3C, 8'd0, B_INCR, 1'b0, 0);
    chk("lit_version_kept", got_back(0), VERSION);

    read_burst(32'h40, 8'd0, B_INCR, 1'b1, 0);
    chk("lit_decerr_data", got_back(0), 32'h0);
    write_burst(32'h40, 8'd0, B_INCR, 1'b1, 1);
    chk("lit_decerr_bresp", 32'(got_b[got_b.size()-1]), 3);

    wd[0] = 32'h0000_000A; wd[1] = 32'h0000_000B; ws[0] = 4'hF; ws[1] = 4'hF;
    write_burst(32'h8, 8'd1, B_FIXED, 1'b0, 2);
    read_burst(32'h8, 8'd1, B_FIXED, 1'b0, 0);
    read_burst(32'h8, 8'd1, B_INCR, 1'b0, 0);
    chk("lit_fixed_last", got_back(1), 32'h0000_000B);

    wd[0] = 32'hC0C0_C0C0; wd[1] = 32'hD0D0_D0D0;
    write_burst(32'h20, 8'd3, B_INCR, 1'b1, 2);
    read_burst(32'h20, 8'd3, B_INCR, 1'b1, 0);
    read_burst(32'h10, 8'd1, B_WRAP, 1'b0, 0);

    read_burst(32'h3C, 8'd1, B_INCR, 1'b1, 0);
    wd[0] = 32'h5555_5555; wd[1] = 32'h6666_6666;
    write_burst(32'h3C, 8'd1, B_INCR, 1'b1, 2);
    chk("lit_worst_bresp", 32'(got_b[got_b.size()-1]), 3);

    aw_hs(32'h0, 8'd3, B_INCR, 1'b0);
    ar_issue(32'h10, 8'd3, B_INCR, 1'b0, 1'b0);
    @(posedge aclk); #1;
    chk("pre_rst_wready", 32'(s_wready), 1);
    chk("pre_rst_rvalid", 32'(s_rvalid), 1);
    #2 aresetn = 1'b0;
    #1;
    chk("mid_rst_rvalid",  32'(s_rvalid),  0);
    chk("mid_rst_wready",  32'(s_wready),  0);
    chk("mid_rst_awready", 32'(s_awready), 0);
    chk("mid_rst_arready", 32'(s_arready), 0);
    exp_r.delete();
    model_reset();
    #20;
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;
    read_burst(32'h0, 8'd0, B_INCR, 1'b0, 0);
    chk("lit_reg0_after_rst", got_back(0), 32'h0);
    read_burst(32'h10, 8'd0, B_INCR, 1'b0, 0);

    repeat (5) @(posedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
